hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard/stall controller; drives the stall and flush inputs of the IF/ID, ID/EXE
//  and EXE/MEM pipeline registers. Detects load-use, multicycle-divider, data-memory-busy and
//  control (taken branch/jump) hazards. Contains a small FSM, a divider watchdog and
//  saturating stall-cycle counters for performance debug.
// PARAMETERS
//  DIV_MAX_CYC  40  divider watchdog limit; cycles in S_DIV before div_err is raised
//  CNT_W        32  width of each perf counter
// PORTS
//  clk             in   1      rising-edge clock
//  nrst            in   1      asynchronous active-low reset
//  id_rs1,id_rs2   in   5      source regs of the instruction in ID
//  id_use_rs1/2    in   1      ID instruction actually reads rs1 / rs2
//  exe_rd          in   5      dest reg of the instruction in EXE
//  exe_wr_en       in   1      EXE instruction writes the regfile
//  exe_is_ltype    in   1      EXE instruction is a load
//  exe_div_valid   in   1      divider op launched from EXE this cycle
//  div_done        in   1      divider result valid (1-cycle pulse)
//  dmem_busy       in   1      data cache/memory not ready; MEM stage must hold
//  exe_redirect    in   1      taken branch/jump resolved in EXE
//  stall_if        out  1      hold PC and IF/ID
//  stall_id        out  1      hold ID/EXE inputs (ID re-presents the same instruction)
//  stall_exe       out  1      hold EXE and EXE/MEM
//  flush_ifid      out  1      zero IF/ID on next edge
//  flush_idexe     out  1      zero ID/EXE on next edge (bubble into EXE)
//  flush_exemem    out  1      zero EXE/MEM on next edge (bubble into MEM)
//  div_err         out  1      1-cycle pulse on divider watchdog expiry
//  cnt_lu,cnt_div,cnt_mem  out CNT_W  saturating stall-cycle counters per cause
// BEHAVIOUR
//  - FSM states: S_RUN, S_DIV, S_MEM. State, watchdog and counters reset asynchronously when
//    nrst=0: state=S_RUN, counters 0, div_err 0. All stall/flush outputs are 0 while nrst=0.
//  - Stall/flush outputs are combinational from the current state and inputs (0-cycle latency).
//    div_err is registered.
//  - Priority within a cycle: mem > div > redirect > load-use.
//  - S_MEM, entered from any state when dmem_busy=1 on a clock edge, and held while busy:
//    stall_if=stall_id=stall_exe=1, all flushes=0, cnt_mem++.
//    dmem_busy is also honoured combinationally in S_RUN/S_DIV (same outputs that cycle).
//    Exit when dmem_busy=0: go to S_DIV if a divide is still outstanding, else S_RUN.
//  - S_DIV, entered from S_RUN on exe_div_valid=1:
//    stall_if=stall_id=stall_exe=1 and flush_exemem=1 (bubbles into MEM), cnt_div++,
//    watchdog++.
//    On div_done=1: stalls drop in that same cycle and the state returns to S_RUN.
//    When watchdog==DIV_MAX_CYC: pulse div_err, return to S_RUN, clear the watchdog.
//    div_done arriving in S_RUN or S_MEM is latched as "done" and is not lost.
//  - Redirect (S_RUN, no mem/div stall): flush_ifid=flush_idexe=1, no stalls.
//    While stall_exe=1, exe_redirect is ignored; the EXE stage re-presents it after release.
//  - Load-use (S_RUN, no higher-priority event):
//    condition is exe_is_ltype & exe_wr_en & exe_rd!=0 &
//    ((id_use_rs1 & id_rs1==exe_rd) | (id_use_rs2 & id_rs2==exe_rd)).
//    Response: stall_if=stall_id=1 and flush_idexe=1 for exactly one cycle, cnt_lu++.
//    The condition clears naturally once the load leaves EXE.
//  - Counters saturate at all-ones and never wrap.
//  - Reset asserted mid-stall aborts the stall immediately.
//    The outstanding-divide flag is cleared; no div_err is raised.
// TESTING
//  1. lw x5 in EXE, add x6,x5,x1 in ID -> stall_if/id=1, flush_idexe=1 for 1 cycle, cnt_lu=1.
//     Repeat with rd=x0 -> no stall.
//  2. exe_div_valid, div_done 33 cycles later -> stall_exe=1 for 33 cycles,
//     flush_exemem=1 during the stall, cnt_div=33, div_err=0.
//  3. exe_div_valid and no div_done -> div_err pulses after 40 cycles, FSM back in S_RUN.
//  4. dmem_busy=1 for 5 cycles while exe_redirect=1 -> no flush during busy;
//     flush_ifid/flush_idexe=1 in the first cycle after busy drops; cnt_mem=5.
//  5. div_done in the same cycle as dmem_busy rises -> S_MEM held, then S_RUN without
//     re-entering S_DIV.
//  6. nrst pulsed low during S_DIV -> all outputs 0 immediately; counters=0; state S_RUN.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard/stall controller.
//
// Drives the stall and flush controls of the IF/ID, ID/EXE and EXE/MEM pipeline
// registers. It covers four hazard causes, highest priority first:
//   data-memory busy > multicycle divide > taken redirect > load-use.
// It also contains a divider watchdog and saturating per-cause stall counters.
//
// Ports
//   clk, nrst                  rising-edge clock, asynchronous active-low reset
//   id_rs1/id_rs2              source registers of the ID instruction
//   id_use_rs1/id_use_rs2      ID instruction really reads rs1 / rs2
//   exe_rd/exe_wr_en           EXE destination register / regfile write enable
//   exe_is_ltype               EXE instruction is a load
//   exe_div_valid              divide launched from EXE this cycle
//   div_done                   divider result valid (1-cycle pulse)
//   dmem_busy                  data memory not ready, MEM stage must hold
//   exe_redirect               taken branch/jump resolved in EXE
//   stall_if/stall_id/stall_exe        hold the corresponding pipeline stage
//   flush_ifid/flush_idexe/flush_exemem bubble the corresponding register
//   div_err                    1-cycle pulse when the divider watchdog expires
//   cnt_lu/cnt_div/cnt_mem     saturating stall-cycle counters per cause
module hazard_ctrl #(
  parameter int DIV_MAX_CYC = 40,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       exe_rd,
  input  logic             exe_wr_en,
  input  logic             exe_is_ltype,
  input  logic             exe_div_valid,
  input  logic             div_done,
  input  logic             dmem_busy,
  input  logic             exe_redirect,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_exe,
  output logic             flush_ifid,
  output logic             flush_idexe,
  output logic             flush_exemem,
  output logic             div_err,
  output logic [CNT_W-1:0] cnt_lu,
  output logic [CNT_W-1:0] cnt_div,
  output logic [CNT_W-1:0] cnt_mem
);

  localparam int WD_W = $clog2(DIV_MAX_CYC + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(DIV_MAX_CYC);
  localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

  typedef enum logic [1:0] {S_RUN, S_DIV, S_MEM} state_t;

  state_t          state, state_nxt;
  logic            div_pend, div_pend_nxt;   // a divide is outstanding
  logic            done_lat, done_lat_nxt;   // div_done seen while not in S_DIV
  logic [WD_W-1:0] wd, wd_nxt;               // divide-stall cycles so far
  logic [WD_W-1:0] wd_inc;
  logic            err_nxt;
  logic            inc_lu, inc_div, inc_mem;
  logic            launch, div_active, done_any, lu_hit;
  logic            sif_c, sid_c, sexe_c, fifid_c, fidexe_c, fexemem_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // A launch only counts from S_RUN; in the other states the divider is
  // already owned by the instruction being held in EXE.
  assign launch     = (state == S_RUN) && exe_div_valid;
  // A completion seen in S_RUN belongs to no launch of this cycle, so it is
  // only honoured once a divide is actually being waited on.
  assign done_any   = (state != S_RUN) && (div_done || done_lat);
  assign div_active = (state == S_DIV) || ((state == S_MEM) && div_pend) || launch;
  // The launch cycle itself is the first divide-stall cycle.
  assign wd_inc     = (launch ? '0 : wd) + WD_ONE;

  assign lu_hit = exe_is_ltype && exe_wr_en && (exe_rd != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == exe_rd)) ||
                   (id_use_rs2 && (id_rs2 == exe_rd)));

  always_comb begin
    state_nxt    = state;
    div_pend_nxt = div_pend;
    done_lat_nxt = done_lat;
    wd_nxt       = wd;
    err_nxt      = 1'b0;
    inc_lu       = 1'b0;
    inc_div      = 1'b0;
    inc_mem      = 1'b0;
    sif_c        = 1'b0;
    sid_c        = 1'b0;
    sexe_c       = 1'b0;
    fifid_c      = 1'b0;
    fidexe_c     = 1'b0;
    fexemem_c    = 1'b0;

    if (dmem_busy) begin
      // Whole pipeline freezes; a redirect waiting in EXE is re-presented later.
      sif_c     = 1'b1;
      sid_c     = 1'b1;
      sexe_c    = 1'b1;
      inc_mem   = 1'b1;
      state_nxt = S_MEM;
      if (launch) begin
        div_pend_nxt = 1'b1;
        wd_nxt       = '0;
        done_lat_nxt = 1'b0;
      end else begin
        done_lat_nxt = done_lat || div_done;
      end
    end else if (div_active && !done_any) begin
      // Hold the divide in EXE and feed bubbles into MEM. The watchdog is
      // frozen during memory stalls and only counts divide-stall cycles.
      sif_c     = 1'b1;
      sid_c     = 1'b1;
      sexe_c    = 1'b1;
      fexemem_c = 1'b1;
      inc_div   = 1'b1;
      done_lat_nxt = 1'b0;
      if (wd_inc == WD_LIM) begin
        err_nxt      = 1'b1;
        state_nxt    = S_RUN;
        div_pend_nxt = 1'b0;
        wd_nxt       = '0;
      end else begin
        state_nxt    = S_DIV;
        div_pend_nxt = 1'b1;
        wd_nxt       = wd_inc;
      end
    end else begin
      if (div_active) begin
        // Divide result consumed: release the stall in this same cycle.
        div_pend_nxt = 1'b0;
        done_lat_nxt = 1'b0;
        wd_nxt       = '0;
      end else begin
        done_lat_nxt = done_lat || div_done;
      end
      state_nxt = S_RUN;
      if (exe_redirect) begin
        fifid_c  = 1'b1;
        fidexe_c = 1'b1;
      end else if (lu_hit) begin
        // One bubble is enough: the load moves to MEM and the match clears.
        sif_c    = 1'b1;
        sid_c    = 1'b1;
        fidexe_c = 1'b1;
        inc_lu   = 1'b1;
      end
    end
  end

  // Outputs are forced low while reset is held, independent of the inputs.
  assign stall_if     = nrst && sif_c;
  assign stall_id     = nrst && sid_c;
  assign stall_exe    = nrst && sexe_c;
  assign flush_ifid   = nrst && fifid_c;
  assign flush_idexe  = nrst && fidexe_c;
  assign flush_exemem = nrst && fexemem_c;

  // ---- state register boundary ----
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= S_RUN;
      div_pend <= 1'b0;
      done_lat <= 1'b0;
      wd       <= '0;
      div_err  <= 1'b0;
      cnt_lu   <= '0;
      cnt_div  <= '0;
      cnt_mem  <= '0;
    end else begin
      state    <= state_nxt;
      div_pend <= div_pend_nxt;
      done_lat <= done_lat_nxt;
      wd       <= wd_nxt;
      div_err  <= err_nxt;
      if (inc_lu)  cnt_lu  <= sat_inc(cnt_lu);
      if (inc_div) cnt_div <= sat_inc(cnt_div);
      if (inc_mem) cnt_mem <= sat_inc(cnt_mem);
    end
  end

endmodule
